nes_controller_reader: RTL

Polls the NES-style game controller over its 3-wire serial interface (latch, pulse, data) and produces the 8-bit button byte consumed by the decode stage's controller-immediate path. The decode stage only samples a static byte; this block owns all controller timing, synchronisation and polarity inversion. It sits at the top level between the controller pins and the CPU's controller input.

---
 rtl/nes_ctrl_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/nes_controller_reader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/nes_ctrl_pkg.sv
// Shared types and constants for the NES controller reader: FSM encoding and
// button bit positions in the reported byte.
package nes_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    READ_LO = 3'd2,
    READ_HI = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is the
// line's idle level so no spurious edge is seen after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_controller_reader.sv
// Periodically polls an NES controller over latch/pulse/data and presents the
// decoded button byte (pressed = 1) with a one-cycle update strobe.
module nes_controller_reader
  import nes_ctrl_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int POLL_PERIOD = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ctrl_data,
  output logic       ctrl_latch,
  output logic       ctrl_pulse,
  output logic [7:0] buttons,
  output logic       buttons_valid
);

  localparam int TIMER_MAX = max_int(POLL_PERIOD, 2 * CLK_DIV);
  localparam int TW        = $clog2(TIMER_MAX);

  localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(2 * CLK_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_IDX   = 3'(NUM_BUTTONS - 1);

  state_t                   state, state_nxt;
  logic [TW-1:0]            timer, timer_nxt;
  logic [2:0]               idx, idx_nxt;
  logic                     sample;
  logic                     sync_data;
  logic [NUM_BUTTONS-1:0]   shift_reg, shift_nxt;

  // Controller data is idle-high (pulled up), so the synchroniser resets to 1.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ctrl_data),
    .q     (sync_data)
  );

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 1'b1;
    idx_nxt   = idx;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        // Timer parks at its terminal value while polling is disabled.
        if (timer == POLL_LAST) begin
          timer_nxt = timer;
          if (enable) begin
            state_nxt = LATCH;
            timer_nxt = '0;
          end
        end
      end
      LATCH: begin
        if (timer == LATCH_LAST) begin
          state_nxt = READ_LO;
          timer_nxt = '0;
          idx_nxt   = '0;
        end
      end
      READ_LO: begin
        if (timer == HALF_LAST) begin
          sample    = 1'b1;
          timer_nxt = '0;
          state_nxt = (idx == LAST_IDX) ? DONE : READ_HI;
        end
      end
      READ_HI: begin
        if (timer == HALF_LAST) begin
          timer_nxt = '0;
          idx_nxt   = idx + 3'd1;
          state_nxt = READ_LO;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // The final bit is merged here so the byte published on entry to DONE is complete.
  always_comb begin
    shift_nxt = shift_reg;
    if (sample) shift_nxt[idx] = ~sync_data;
  end

  always_ff @(posedge clk) begin
    shift_reg <= shift_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      idx           <= '0;
      ctrl_latch    <= 1'b0;
      ctrl_pulse    <= 1'b0;
      buttons       <= 8'h00;
      buttons_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      idx           <= idx_nxt;
      ctrl_latch    <= (state_nxt == LATCH);
      ctrl_pulse    <= (state_nxt == READ_HI);
      buttons_valid <= (state_nxt == DONE);
      if (state_nxt == DONE) buttons <= shift_nxt;
    end
  end

endmodule
